// File: rtl/tap_seq_gen.sv
// rtl/tap_seq_gen.sv - programmable one-hot tap sequence generator with hold/gap timing
module tap_seq_gen #(
    parameter int HOLD = 4,
    parameter int GAP  = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] steps,
    input  logic [2:0] len,
    output logic [3:0] sw,
    output logic       busy,
    output logic [1:0] step_idx,
    output logic       done
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_TAP,
        S_GAP,
        S_DONE
    } state_t;

    localparam int MAXV = (HOLD > GAP) ? HOLD : GAP;
    localparam int CW   = (MAXV > 1) ? $clog2(MAXV + 1) : 1;
    localparam logic [CW-1:0] HOLD_LD = CW'(HOLD - 1);
    localparam logic [CW-1:0] GAP_LD  = CW'((GAP > 0) ? (GAP - 1) : 0);

    state_t        state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [7:0]    steps_q, steps_n;
    logic [2:0]    len_q, len_n;
    logic [3:0]    sw_n;
    logic          busy_n;
    logic [1:0]    idx_n;
    logic          done_n;

    logic [1:0]    nxt_idx;
    logic [7:0]    nxt_shift;
    logic          more;

    function automatic logic [3:0] onehot(input logic [1:0] i);
        return 4'b0001 << i;
    endfunction

    assign nxt_idx   = step_idx + 2'd1;
    assign nxt_shift = steps_q >> {nxt_idx, 1'b0};
    assign more      = ({1'b0, step_idx} + 3'd1) < len_q;

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        steps_n = steps_q;
        len_n   = len_q;
        sw_n    = sw;
        busy_n  = busy;
        idx_n   = step_idx;
        done_n  = 1'b0;
        case (state)
            S_IDLE: begin
                sw_n   = 4'b0000;
                busy_n = 1'b0;
                idx_n  = 2'd0;
                if (start) begin
                    steps_n = steps;
                    len_n   = (len > 3'd4) ? 3'd4 : len;
                    if (len != 3'd0) begin
                        state_n = S_TAP;
                        cnt_n   = HOLD_LD;
                        sw_n    = onehot(steps[1:0]);
                        busy_n  = 1'b1;
                    end else begin
                        state_n = S_DONE;
                        done_n  = 1'b1;
                    end
                end
            end
            S_TAP: begin
                if (cnt != '0) begin
                    cnt_n = cnt - CW'(1);
                end else if (GAP > 0) begin
                    state_n = S_GAP;
                    cnt_n   = GAP_LD;
                    sw_n    = 4'b0000;
                end else if (more) begin
                    // Zero-gap mode: chain straight into the next tap
                    cnt_n = HOLD_LD;
                    idx_n = nxt_idx;
                    sw_n  = onehot(nxt_shift[1:0]);
                end else begin
                    state_n = S_DONE;
                    sw_n    = 4'b0000;
                    busy_n  = 1'b0;
                    idx_n   = 2'd0;
                    done_n  = 1'b1;
                end
            end
            S_GAP: begin
                if (cnt != '0) begin
                    cnt_n = cnt - CW'(1);
                end else if (more) begin
                    state_n = S_TAP;
                    cnt_n   = HOLD_LD;
                    idx_n   = nxt_idx;
                    sw_n    = onehot(nxt_shift[1:0]);
                end else begin
                    state_n = S_DONE;
                    sw_n    = 4'b0000;
                    busy_n  = 1'b0;
                    idx_n   = 2'd0;
                    done_n  = 1'b1;
                end
            end
            S_DONE: begin
                state_n = S_IDLE;
                sw_n    = 4'b0000;
                busy_n  = 1'b0;
                idx_n   = 2'd0;
            end
            default: begin
                state_n = S_IDLE;
                sw_n    = 4'b0000;
                busy_n  = 1'b0;
                idx_n   = 2'd0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= S_IDLE;
            cnt      <= '0;
            steps_q  <= 8'd0;
            len_q    <= 3'd0;
            sw       <= 4'b0000;
            busy     <= 1'b0;
            step_idx <= 2'd0;
            done     <= 1'b0;
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            steps_q  <= steps_n;
            len_q    <= len_n;
            sw       <= sw_n;
            busy     <= busy_n;
            step_idx <= idx_n;
            done     <= done_n;
        end
    end

endmodule

// File: doc/tap_seq_gen.md
# tap_seq_gen

Programmable tap-sequence generator driving a 4-bit one-hot switch bus with fixed hold and gap timing. It is the transmit side of the switch-tap sequence detector: its `sw` output feeds a detector's `sw` input in loopback benches and in self-test builds. The generator is loaded on a start pulse with up to four tap indices. It plays each tap as a one-hot pattern for HOLD cycles, separated by GAP idle cycles, then signals completion.

## Interface
- `HOLD`, default 4: cycles each tap pattern is driven. Legal range ≥1.
- `GAP`, default 2: cycles of `4'b0000` after each tap. Legal range ≥0; 0 gives back-to-back taps.
- `clk` in 1: single clock; all state updates on its rising edge.
- `rst` in 1: reset, asynchronous, active-low.
- `start` in 1: request to play; sampled only in IDLE.
- `steps` in 8: tap indices; step k uses `steps[2k+1:2k]`; index i maps to `sw = 1<<i`.
- `len` in 3: number of steps to play, 0..4; values 5..7 are clamped to 4.
- `sw` out 4: registered tap output, one-hot or zero.
- `busy` out 1: high while a sequence is playing (TAP/GAP states).
- `step_idx` out 2: index of the step currently being played; 0 when idle.
- `done` out 1: one-cycle pulse after the sequence completes.

## Operation
- States: IDLE, TAP, GAP, DONE. State and all outputs are registered.
- Reset (`rst`=0, asynchronous): state→IDLE, `sw`=0, `busy`=0, `done`=0, `step_idx`=0, counters=0. Takes effect immediately, including mid-sequence. The sequence is abandoned and is not resumed after reset releases.
- IDLE, `start`=1:
  - Latch `steps` and clamped `len`.
  - If `len`≠0: go to TAP with `step_idx`=0, `sw`=onehot(`steps[1:0]`), `busy`=1.
  - If `len`=0: go to DONE directly with no taps.
- TAP: hold `sw` for HOLD cycles.
  - Then, if GAP>0: go to GAP, `sw`=0.
  - Else if more steps remain: stay in TAP with the next step's pattern.
  - Else: go to DONE.
- GAP: `sw`=0 for GAP cycles.
  - If more steps remain: go to TAP, increment `step_idx`, drive that step's pattern.
  - Else: go to DONE.
- DONE: `done`=1, `busy`=0, `sw`=0, `step_idx`=0 for exactly one cycle, then IDLE.
- `start` is ignored in TAP, GAP and DONE, with no queuing.
- `steps`/`len` changes after the latching edge have no effect on the running sequence.
- One down-counter is shared by TAP and GAP. Width is the number of bits needed to hold max(HOLD,GAP). It is reloaded on every state entry.

## Timing
- The edge that samples `start`=1 in IDLE produces the first tap on `sw` in the following cycle, with `busy`=1 in that same cycle.
- Each step occupies exactly HOLD+GAP cycles.
- Busy duration = `len`×(HOLD+GAP) cycles. `done` is high in the next cycle; the earliest new start is sampled on the edge after that.
- `len`=0: `done` is high in the cycle after the start edge; `busy` never rises.
- With GAP=0, consecutive equal indices produce a continuous pattern of `len`×HOLD cycles with no gap.
- `sw` never shows more than one bit set, including across transitions, since all outputs are registered.

## Test plan
- Reset values:
  - Stimulus: `rst`=0 asynchronously, mid-cycle, no clock.
  - Required: `sw`=0, `busy`=0, `done`=0, `step_idx`=0 immediately.
- Full sequence:
  - Stimulus: HOLD=4, GAP=2, `steps`=8'b11_10_01_00, `len`=4, `start` pulse.
  - Required: `sw` = 0001×4, 0000×2, 0010×4, 0000×2, 0100×4, 0000×2, 1000×4, 0000×2; `busy` high for 24 cycles; `done` in cycle 25; `step_idx` follows 0,1,2,3.
- Detector loopback:
  - Stimulus: `steps`=8'b00_11_01_00, `len`=3, output driven into a tap detector.
  - Required: detector walks Idle→Tap1→Tap2→Idle; its LED shows 01,10,11,01.
- Clamp and zero length:
  - Stimulus 1: `len`=7. Required: exactly 4 taps.
  - Stimulus 2: `len`=0. Required: `done` 1 cycle after start, `sw` stays 0, `busy` stays 0.
- Start while busy and GAP=0:
  - Stimulus 1: `start` re-pulsed during TAP and during DONE. Required: no effect, timing unchanged.
  - Stimulus 2: GAP=0, `steps`=8'b00_00_01_01, `len`=2. Required: `sw`=0010 for 8 contiguous cycles.
- Reset mid-operation:
  - Stimulus: assert `rst`=0 during step 2 TAP, release, then wait 20 cycles.
  - Required: `sw`=0 immediately; no `done` pulse; IDLE held until a new `start`.
